// File: rtl/serial_twos_comp_ctrl.sv
// serial_twos_comp_ctrl: round-robin front end for a bit-serial two's-complement engine.
// Streams the granted word LSB-first through copy-to-first-one/invert-rest and returns the negation.
module serial_twos_comp_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             t_clk,
    input  logic             r,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             ser_vld,
    output logic             ser_out,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);
    localparam int AW = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_shift, r_result;
    logic [AW-1:0]    r_asm;
    logic [CW-1:0]    r_cnt;
    logic             r_seen, r_ptr, r_id, r_done_id, r_ovf, r_gnt0, r_gnt1;
    logic             w_accept, w_pick1, w_b, w_ser, w_last;

    assign w_b     = r_shift[0];
    assign w_ser   = w_b ^ r_seen;
    assign w_last  = r_cnt == CW'(WIDTH - 1);
    // r_ptr is the last-served requester; on a tie the other one wins
    assign w_pick1 = req1 & (~req0 | ~r_ptr);

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            IDLE: begin
                w_accept = req0 | req1;
                w_next   = w_accept ? SHIFT : IDLE;
            end
            SHIFT:   w_next = w_last ? DONE : SHIFT;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge t_clk or posedge r) begin
        if (r) r_state <= IDLE;
        else   r_state <= w_next;
    end

    always_ff @(posedge t_clk or posedge r) begin
        if (r) begin
            r_shift   <= '0;
            r_asm     <= '0;
            r_result  <= '0;
            r_cnt     <= '0;
            r_seen    <= 1'b0;
            r_ptr     <= 1'b1;
            r_id      <= 1'b0;
            r_done_id <= 1'b0;
            r_ovf     <= 1'b0;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
        end else begin
            r_gnt0 <= w_accept & ~w_pick1;
            r_gnt1 <= w_accept & w_pick1;
            if (w_accept) begin
                r_shift <= w_pick1 ? data1 : data0;
                r_id    <= w_pick1;
                r_ptr   <= w_pick1;
                r_seen  <= 1'b0;
                r_cnt   <= '0;
            end else if (r_state == SHIFT) begin
                r_seen  <= r_seen | w_b;
                r_asm   <= AW'({w_ser, r_asm} >> 1);
                r_shift <= r_shift >> 1;
                r_cnt   <= r_cnt + CW'(1);
                if (w_last) begin
                    r_result  <= {w_ser, r_asm};
                    r_done_id <= r_id;
                    r_ovf     <= ~r_seen & w_b;
                end
            end
        end
    end

    assign gnt0    = r_gnt0;
    assign gnt1    = r_gnt1;
    assign busy    = r_state != IDLE;
    assign ser_vld = r_state == SHIFT;
    assign ser_out = ser_vld & w_ser;
    assign done    = r_state == DONE;
    assign done_id = r_done_id;
    assign result  = r_result;
    assign ovf     = r_ovf;
endmodule
